// File: rtl/systolic_result_drain.sv
// systolic_result_drain: pulls results off the bottom edge of the PE array,
// buffers the N x N tile and streams it row-major over a val/rdy port.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          drain request from the controller (ignored while busy)
//   col_data       bottom-edge words, column c at [c*W +: W]
//   shift_result   shift enable driven into the array
//   out_val/rdy    result handshake; out_data/out_row/out_col describe the word
//   busy           FSM not idle
//   done           single-cycle pulse after the last word is accepted
module systolic_result_drain #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int N          = 4,
  localparam int W         = INT_WIDTH + FRAC_WIDTH,
  localparam int AW        = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N*W-1:0]  col_data,
  output logic            shift_result,
  output logic            out_val,
  input  logic            out_rdy,
  output logic [W-1:0]    out_data,
  output logic [AW-1:0]   out_row,
  output logic [AW-1:0]   out_col,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL,
    DRAIN
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] sft_cnt_q, sft_cnt_d;
  logic [AW-1:0] cap_cnt_q, cap_cnt_d;
  logic [AW-1:0] rd_row_q, rd_row_d;
  logic [AW-1:0] rd_col_q, rd_col_d;
  logic          strb_q;
  logic          done_q, done_d;
  logic [AW-1:0] cap_row;
  logic [W-1:0]  mem_q [N][N];

  always_comb begin
    state_d   = state_q;
    sft_cnt_d = sft_cnt_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    done_d    = 1'b0;
    cap_cnt_d = cap_cnt_q;

    // One strobe per shifted row; wraps back after the top row lands.
    if (strb_q) begin
      cap_cnt_d = (cap_cnt_q == LAST) ? '0 : cap_cnt_q + AW'(1);
    end

    unique case (state_q)
      IDLE: begin
        cap_cnt_d = '0;
        if (start) begin
          state_d   = SHIFT;
          sft_cnt_d = '0;
        end
      end
      SHIFT: begin
        sft_cnt_d = sft_cnt_q + AW'(1);
        if (sft_cnt_q == LAST) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        // Last capture lands on this edge.
        state_d  = DRAIN;
        rd_row_d = '0;
        rd_col_d = '0;
      end
      DRAIN: begin
        if (out_rdy) begin
          if (rd_col_q == LAST) begin
            rd_col_d = '0;
            if (rd_row_q == LAST) begin
              rd_row_d = '0;
              state_d  = IDLE;
              done_d   = 1'b1;
            end else begin
              rd_row_d = rd_row_q + AW'(1);
            end
          end else begin
            rd_col_d = rd_col_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sft_cnt_q <= '0;
      cap_cnt_q <= '0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      strb_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sft_cnt_q <= sft_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      rd_row_q  <= rd_row_d;
      rd_col_q  <= rd_col_d;
      // PE outputs appear one cycle after each shift.
      strb_q    <= shift_result;
      done_q    <= done_d;
    end
  end

  // Bottom row leaves the array first.
  assign cap_row = LAST - cap_cnt_q;

  always_ff @(posedge clk) begin
    if (strb_q) begin
      for (int c = 0; c < N; c++) begin
        mem_q[cap_row][c] <= col_data[c*W +: W];
      end
    end
  end

  assign shift_result = (state_q == SHIFT);
  assign busy         = (state_q != IDLE);
  assign out_val      = (state_q == DRAIN);
  assign done         = done_q;
  assign out_data     = out_val ? mem_q[rd_row_q][rd_col_q] : '0;
  assign out_row      = out_val ? rd_row_q : '0;
  assign out_col      = out_val ? rd_col_q : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: drives a 2x2 and a 4x4 drain with an array
// model and checks the streamed words against an expected-word queue.
module tb_systolic_result_drain;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int          r;
    int          c;
    logic [15:0] d;
  } wd_t;

  // ---------------- instance A: N=2 ----------------
  logic        a_start, a_rdy, a_sh_o, a_val, a_busy, a_done;
  logic [31:0] a_cd = '0;
  logic [15:0] a_data;
  logic [0:0]  a_row, a_col;
  logic [15:0] a_mat [2][2];
  int          a_k = 0;
  wd_t         aq[$];
  bit          a_xd = 0;

  systolic_result_drain #(
    .INT_WIDTH(8), .FRAC_WIDTH(8), .N(2)
  ) ua (
    .clk(clk), .reset(reset), .start(a_start), .col_data(a_cd),
    .shift_result(a_sh_o), .out_val(a_val), .out_rdy(a_rdy),
    .out_data(a_data), .out_row(a_row), .out_col(a_col),
    .busy(a_busy), .done(a_done)
  );

  // ---------------- instance B: N=4 ----------------
  logic        b_start, b_rdy, b_sh_o, b_val, b_busy, b_done;
  logic [63:0] b_cd = '0;
  logic [15:0] b_data;
  logic [1:0]  b_row, b_col;
  logic [15:0] b_mat [4][4];
  int          b_k = 0;
  wd_t         bq[$];
  bit          b_xd = 0;

  systolic_result_drain #(
    .INT_WIDTH(8), .FRAC_WIDTH(8), .N(4)
  ) ub (
    .clk(clk), .reset(reset), .start(b_start), .col_data(b_cd),
    .shift_result(b_sh_o), .out_val(b_val), .out_rdy(b_rdy),
    .out_data(b_data), .out_row(b_row), .out_col(b_col),
    .busy(b_busy), .done(b_done)
  );

  // PE array models: each shift pushes the next row (bottom first) onto
  // the bottom edge one cycle later.
  always @(posedge clk) begin
    if (!a_sh_o) a_k <= 0;
    else begin
      if (a_k < 2) a_cd <= {a_mat[1-a_k][1], a_mat[1-a_k][0]};
      a_k <= a_k + 1;
    end
  end

  always @(posedge clk) begin
    if (!b_sh_o) b_k <= 0;
    else begin
      if (b_k < 4)
        for (int c = 0; c < 4; c++) b_cd[c*16 +: 16] <= b_mat[3-b_k][c];
      b_k <= b_k + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Stream checkers: every accepted word must be the queue head, done must
  // follow the final word by one cycle, outputs zero when not valid.
  initial forever begin
    @(negedge clk);
    if (reset) a_xd = 0;
    else begin
      chk("a_done", a_done, a_xd);
      a_xd = 0;
      if (!a_val) chk("a_idle_out", {a_data, a_row, a_col}, 0);
      else if (aq.size() == 0) chk("a_extra_word", a_val, 0);
      else begin
        chk("a_data", a_data, aq[0].d);
        chk("a_row", a_row, aq[0].r);
        chk("a_col", a_col, aq[0].c);
        if (a_rdy) begin
          a_xd = (aq[0].r == 1 && aq[0].c == 1);
          void'(aq.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset) b_xd = 0;
    else begin
      chk("b_done", b_done, b_xd);
      b_xd = 0;
      if (!b_val) chk("b_idle_out", {b_data, b_row, b_col}, 0);
      else if (bq.size() == 0) chk("b_extra_word", b_val, 0);
      else begin
        chk("b_data", b_data, bq[0].d);
        chk("b_row", b_row, bq[0].r);
        chk("b_col", b_col, bq[0].c);
        if (b_rdy) begin
          b_xd = (bq[0].r == 3 && bq[0].c == 3);
          void'(bq.pop_front());
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [15:0] m00, m01, m10, m11);
    a_mat[0][0] = m00; a_mat[0][1] = m01;
    a_mat[1][0] = m10; a_mat[1][1] = m11;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) aq.push_back('{r, c, a_mat[r][c]});
  endtask

  task automatic b_load(input logic [15:0] base, input int mul);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        b_mat[r][c] = base + 16'((r*4 + c) * mul);
        bq.push_back('{r, c, b_mat[r][c]});
      end
  endtask

  // Returns at the negedge of the done cycle.
  task automatic a_wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_done) begin ok = 1; break; end
    end
    chk(nm, ok, 1);
    chk({nm, "_busy"}, a_busy, 0);
    chk({nm, "_left"}, aq.size(), 0);
  endtask

  task automatic b_wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (b_done) begin ok = 1; break; end
    end
    chk(nm, ok, 1);
    chk({nm, "_busy"}, b_busy, 0);
    chk({nm, "_left"}, bq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nsh;
    bit ok;
    a_start = 0; b_start = 0; a_rdy = 1; b_rdy = 1;
    repeat (3) step;
    @(negedge clk);
    chk("rst_a_outs", {a_sh_o, a_val, a_busy, a_done}, 0);
    chk("rst_a_data", {a_data, a_row, a_col}, 0);
    chk("rst_b_outs", {b_sh_o, b_val, b_busy, b_done}, 0);
    chk("rst_b_data", {b_data, b_row, b_col}, 0);
    step;
    reset = 0;
    step;

    // T1: basic 2x2 drain with exact timing
    a_load(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    a_start = 1; step; a_start = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("t1_shift", a_sh_o, (i <= 2));
      chk("t1_val", a_val, (i >= 4));
      chk("t1_busy", a_busy, 1);
      if (i == 4) chk("t1_first", {a_data, a_row, a_col}, {16'h0001, 2'b00});
      if (i == 5) chk("t1_second", {a_data, a_row, a_col}, {16'h0002, 2'b01});
      step;
    end
    a_wait_done("t1_done");
    step;

    // T2: stall on second word
    a_load(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    a_start = 1; step; a_start = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) a_rdy = 0;
      if (i == 8) a_rdy = 1;
      @(negedge clk);
      if (i >= 5 && i <= 7)
        chk("t2_hold", {a_data, a_row, a_col}, {16'h0002, 2'b01});
      step;
    end
    a_wait_done("t2_done");
    step;

    // T3: start ignored during SHIFT and DRAIN
    a_load(16'h00a0, 16'h00b1, 16'h00c2, 16'h00d3);
    a_start = 1; step; a_start = 0;
    nsh = 0;
    for (int i = 1; i <= 7; i++) begin
      a_start = (i == 1 || i == 5);
      @(negedge clk);
      nsh += int'(a_sh_o);
      step;
    end
    a_start = 0;
    a_wait_done("t3_done");
    chk("t3_nshift", nsh, 2);
    step;
    @(negedge clk);
    chk("t3_idle", {a_busy, a_sh_o}, 0);
    step;

    // T4: reset in DRAIN after two handshakes
    a_load(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    a_start = 1; step; a_start = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      step;
    end
    a_rdy = 0; reset = 1;
    step;
    reset = 0;
    aq.delete();
    @(negedge clk);
    chk("t4_after_rst", {a_val, a_busy, a_sh_o, a_done}, 0);
    step;
    a_rdy = 1;
    a_load(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    a_start = 1; step; a_start = 0;
    a_wait_done("t4_done");

    // T5: start in the done cycle
    a_load(16'hdead, 16'hbeef, 16'hcafe, 16'hf00d);
    a_start = 1;
    step;
    a_start = 0;
    @(negedge clk);
    chk("t5_shift", a_sh_o, 1);
    chk("t5_busy", a_busy, 1);
    step;
    a_wait_done("t5_done");
    step;

    // T6: 4x4 drain, distinct values, latency 6
    b_load(16'h0100, 1);
    b_start = 1; step; b_start = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("t6_shift", b_sh_o, (i <= 4));
      chk("t6_val", b_val, (i == 6));
      if (i == 6) chk("t6_first", {b_data, b_row, b_col}, {16'h0100, 4'h0});
      step;
    end
    b_wait_done("t6_done");
    step;

    // T7: 4x4 drain with periodic back-pressure
    b_load(16'h5a00, 7);
    b_start = 1; step; b_start = 0;
    ok = 0;
    for (int k = 0; k < 80; k++) begin
      b_rdy = (k % 3 != 2);
      @(negedge clk);
      if (b_done) begin ok = 1; break; end
      step;
    end
    b_rdy = 1;
    chk("t7_done", ok, 1);
    chk("t7_left", bq.size(), 0);
    repeat (3) step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
